jk_cmd_sequencer: RTL and testbench
===================================

// Module: jk_cmd_sequencer
// PURPOSE
//  Upstream driver for the JK flip-flop stage. Buffers HOLD/CLEAR/SET/TOGGLE commands
//  arriving on a valid/ready interface in a small FIFO. Replays each command on j/k for
//  (rpt+1) consecutive cycles. Keeps q_exp, a shadow copy of the downstream flop's Q,
//  so the consumer can be cross-checked.
// PARAMETERS
//  DEPTH  4  command FIFO entries (>=2)
//  RPT_W  4  width of per-command repeat count; a command lasts 1..2**RPT_W cycles
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    reset, asynchronous, active-high
//  cmd_valid  in   1                    command offered
//  cmd_ready  out  1                    FIFO can accept the command
//  cmd_op     in   2                    {J,K}: 00 hold, 01 clear, 10 set, 11 toggle
//  cmd_rpt    in   RPT_W                extra cycles to hold the command (0 = one cycle)
//  flush      in   1                    synchronous abort: drop queue and active command
//  j          out  1                    J drive to the flop stage (registered)
//  k          out  1                    K drive to the flop stage (registered)
//  q_exp      out  1                    expected flop Q after the same edge
//  busy       out  1                    command active or FIFO non-empty
//  level      out  $clog2(DEPTH+1)      FIFO occupancy
//  done       out  1                    1-cycle pulse when the last command finishes
// BEHAVIOUR
//  Reset (async): j=0, k=0, q_exp=0, busy=0, level=0, done=0, FSM=IDLE, counter=0.
//   FIFO pointers are cleared. q_exp=0 matches the flop's reset value.
//  Accept: on posedge when cmd_valid & cmd_ready, write {cmd_op,cmd_rpt} into the FIFO.
//   cmd_ready = (level<DEPTH) & ~flush. There is no bypass path.
//   When full, ready stays 0 even if a pop happens in the same cycle.
//  FSM states: IDLE and ISSUE.
//   IDLE, FIFO non-empty: pop head; load {j,k}=op and cnt=rpt; go to ISSUE.
//   IDLE, FIFO empty: j=k=0.
//   ISSUE, cnt!=0: hold j,k; cnt-=1.
//   ISSUE, cnt==0, FIFO non-empty: pop the next command back-to-back (no bubble).
//   ISSUE, cnt==0, FIFO empty: j=k=0; go to IDLE; done=1 for one cycle.
//  Latency: command accepted at edge N into an empty, idle block:
//   j/k drive it from edge N+1; the downstream Q reflects it after edge N+2.
//  Push and pop in the same edge: level is unchanged; both operations take effect.
//  q_exp: updates every edge from the j/k values present before that edge.
//   00 -> keep, 01 -> 0, 10 -> 1, 11 -> ~q_exp. This mirrors the flop sampling j/k.
//  flush (sync, priority over accept and pop):
//   FIFO emptied, j=k=0, cnt=0, FSM=IDLE, level=0, done=0.
//   q_exp still applies the pre-edge j/k on the flush edge.
//  busy = (FSM==ISSUE) | (level!=0). It is combinational from registers.
//  Wrap-around: pointers wrap modulo DEPTH. Occupancy is tracked by level, not by
//   pointer comparison.
//  Reset mid-command: everything returns to reset values immediately. The queue is lost.
// TESTING
//  1) Reset, then one SET with rpt=0 at edge 1.
//     -> j,k=10 during cycle 2 only; q_exp=1 after edge 3; done pulse at edge 3.
//  2) TOGGLE with rpt=3.
//     -> j,k=11 for exactly 4 cycles; q_exp sequence 1,0,1,0; then j,k=00 and done=1.
//  3) Push 4 commands back-to-back (DEPTH=4) while the first is still issuing.
//     -> cmd_ready falls at level=4; no bubble between commands; level drains 4..0.
//  4) Hold cmd_valid high with the FIFO full for 5 cycles.
//     -> no write occurs; no entry is lost or duplicated; ready returns 1 the cycle after a pop.
//  5) Assert flush during a rpt=7 CLEAR with 2 commands queued.
//     -> next cycle j,k=00, level=0, busy=0, done=0; q_exp holds its value.
//  6) Assert async rst mid-ISSUE between clock edges.
//     -> all outputs go to 0 at once; a new command after release follows the scenario-1 timing.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues J/K commands and replays each for rpt+1 cycles,
// keeping q_exp as a shadow of the downstream JK flop output.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int RPT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [RPT_W-1:0]             cmd_rpt,
  input  logic                         flush,
  output logic                         j,
  output logic                         k,
  output logic                         q_exp,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         done
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 2 + RPT_W;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t           state, state_d;
  logic [RPT_W-1:0] cnt, cnt_d;
  logic             j_d, k_d, done_d;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop, empty;
  logic [1:0]       head_op;
  logic [RPT_W-1:0] head_rpt;

  logic go, run, load, fin;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (level == '0);
  assign cmd_ready = (level < FULL) & ~flush;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state == ISSUE) | ~empty;
  assign {head_op, head_rpt} = mem[rd_ptr];

  // Mutually exclusive sequencing conditions.
  assign go   = ~flush;
  assign run  = go & (state == ISSUE)
              & (cnt != '0);
  assign load = go & ~run & ~empty;
  assign fin  = go & (state == ISSUE)
              & (cnt == '0) & empty;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    j_d     = j;
    k_d     = k;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (1'b1)
      flush: begin
        state_d = IDLE;
        cnt_d   = '0;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end
      run: begin
        cnt_d = cnt - RPT_W'(1);
      end
      load: begin
        pop        = 1'b1;
        state_d    = ISSUE;
        cnt_d      = head_rpt;
        {j_d, k_d} = head_op;
      end
      fin: begin
        state_d = IDLE;
        j_d     = 1'b0;
        k_d     = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        j_d = 1'b0;
        k_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      j     <= j_d;
      k     <= k_d;
      done  <= done_d;
    end
  end

  // Shadow of the downstream flop: samples the j/k it sees on each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_exp <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b01:   q_exp <= 1'b0;
        2'b10:   q_exp <= 1'b1;
        2'b11:   q_exp <= ~q_exp;
        default: q_exp <= q_exp;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_rpt};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed stimulus with per-cycle expected outputs
// queued to a scoreboard and checked by an independent monitor.
module tb_jk_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_rpt;
  logic       flush;
  logic       j;
  logic       k;
  logic       q_exp;
  logic       busy;
  logic [2:0] level;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] jk;
    logic       q;
    logic       dn;
    logic       bz;
    logic [2:0] lvl;
    logic       rdy;
  } exp_t;

  exp_t sbq[$];

  jk_cmd_sequencer #(
    .DEPTH(4),
    .RPT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rpt   (cmd_rpt),
    .flush     (flush),
    .j         (j),
    .k         (k),
    .q_exp     (q_exp),
    .busy      (busy),
    .level     (level),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] a,
    input logic [31:0] e
  );
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what must appear after the edge.
  task automatic step(
    input int v, input int op, input int rpt,
    input int fl, input int ejk, input int eq,
    input int ed, input int eb, input int el,
    input int er
  );
    exp_t e;
    cmd_valid = 1'(v);
    cmd_op    = 2'(op);
    cmd_rpt   = 4'(rpt);
    flush     = 1'(fl);
    e.jk  = 2'(ejk);
    e.q   = 1'(eq);
    e.dn  = 1'(ed);
    e.bz  = 1'(eb);
    e.lvl = 3'(el);
    e.rdy = 1'(er);
    sbq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("jk",    32'({j, k}),   32'(e.jk));
        chk("q_exp", 32'(q_exp),    32'(e.q));
        chk("done",  32'(done),     32'(e.dn));
        chk("busy",  32'(busy),     32'(e.bz));
        chk("level", 32'(level),    32'(e.lvl));
        chk("ready", 32'(cmd_ready), 32'(e.rdy));
      end
    end
  end

  task automatic rst_chk(input string tag);
    chk({tag, "_j"},     32'(j),     32'd0);
    chk({tag, "_k"},     32'(k),     32'd0);
    chk({tag, "_q"},     32'(q_exp), 32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
  endtask

  task automatic single_set;
    step(1, 2'b10, 0, 0, 2'b00, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 2'b10, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_rpt   = 4'd0;
    flush     = 1'b0;
    #3;
    rst_chk("reset");
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // single SET, rpt=0
    single_set();

    // TOGGLE rpt=3 starting from q=1
    step(1, 2'b11, 3, 0, 2'b00, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b11, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b11, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 1);

    // fill behind a CLEAR rpt=7, then hold valid while full
    step(1, 2'b01, 7, 0, 2'b00, 1, 0, 1, 1, 1);
    step(1, 2'b10, 0, 0, 2'b01, 1, 0, 1, 1, 1);
    step(1, 2'b00, 0, 0, 2'b01, 0, 0, 1, 2, 1);
    step(1, 2'b11, 0, 0, 2'b01, 0, 0, 1, 3, 1);
    step(1, 2'b10, 1, 0, 2'b01, 0, 0, 1, 4, 0);
    for (int i = 0; i < 4; i++)
      step(1, 2'b11, 2, 0, 2'b01, 0, 0, 1, 4, 0);
    step(1, 2'b11, 2, 0, 2'b10, 0, 0, 1, 3, 1);
    step(1, 2'b11, 2, 0, 2'b00, 1, 0, 1, 3, 1);
    step(0, 0, 0, 0, 2'b11, 1, 0, 1, 2, 1);
    step(0, 0, 0, 0, 2'b10, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 2'b10, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b11, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);

    // flush mid CLEAR rpt=7 with two queued, valid offered on flush
    step(1, 2'b10, 0, 0, 2'b00, 0, 0, 1, 1, 1);
    step(1, 2'b01, 7, 0, 2'b10, 0, 0, 1, 1, 1);
    step(1, 2'b11, 0, 0, 2'b01, 1, 0, 1, 1, 1);
    step(1, 2'b10, 0, 0, 2'b01, 0, 0, 1, 2, 1);
    step(0, 0, 0, 0, 2'b01, 0, 0, 1, 2, 1);
    step(1, 2'b10, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1);

    // flush during SET: q_exp keeps what the pre-edge j/k give
    step(1, 2'b10, 2, 0, 2'b00, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 2'b10, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b10, 1, 0, 1, 0, 1);
    step(0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 1);

    // async reset mid-ISSUE of a TOGGLE
    step(1, 2'b11, 3, 0, 2'b00, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b11, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 1);
    #1;
    rst = 1'b1;
    #1;
    rst_chk("midrst");
    @(negedge clk);
    #1;
    rst = 1'b0;
    single_set();

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
